axis_testpattern_generator_mc: RTL
==================================

Name: axis_testpattern_generator_mc

Overview:
Multi-channel, multi-mode successor of the single-channel AXI-Stream counter test-pattern generator. It emits NUM_CHANNELS packed samples per beat at a rate set by a clock divider. Patterns are sawtooth counter, triangle counter, constant and PRBS. Packets are framed with TLAST, and an overrun flag records sample ticks lost to back-pressure. It sits at the head of DSP/DAC datapaths as a bring-up and verification source.

Parameters:
TDATA_WIDTH, 24, per-channel sample width; legal range 8..32.
NUM_CHANNELS, 2, channels packed in m_axis_tdata; channel c occupies bits [c*TDATA_WIDTH +: TDATA_WIDTH].
COUNTER_START, 1, counter low bound and constant-mode value.
COUNTER_END, 10, counter high bound; COUNTER_END - COUNTER_START >= COUNTER_INCR.
COUNTER_INCR, 1, counter step; must be >= 1.
DIVIDER, 5, clock cycles per sample tick; must be >= 1 (1 = tick every cycle).
PACKET_LEN, 8, beats per packet; must be >= 1.
LFSR_SEED, 32'h0000_0001, PRBS reset state; must be nonzero.

Ports:
m_axis_aclk  in  1  clock
m_axis_areset  in  1  asynchronous active-high reset
enable  in  1  run/pause
mode  in  2  0 = sawtooth, 1 = triangle, 2 = constant, 3 = PRBS
m_axis_tdata  out  NUM_CHANNELS*TDATA_WIDTH  packed samples
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of packet
overrun  out  1  sticky: a tick was lost because a beat was still pending

Behaviour:
- Reset (async assert, sync release):
  - tvalid = 0, tlast = 0, tdata = 0, overrun = 0.
  - div_cnt = 0, beat_cnt = 0, value = COUNTER_START, dir = up, lfsr = LFSR_SEED.
  - active_mode = 0.
- Divider:
  - While enable = 1, div_cnt counts 0..DIVIDER-1 and wraps; a tick fires in the cycle where div_cnt = DIVIDER-1.
  - enable = 0 clears div_cnt to 0 and produces no ticks. Pattern state, beat_cnt and any pending beat are retained, so the stream resumes where it paused.
- Beat generation:
  - A tick with tvalid = 0, or with tvalid & tready in the same cycle, loads a new beat. tvalid = 1 from the next edge; latency is 1 cycle after the tick.
  - The first beat after reset release with enable = 1 is valid on the DIVIDER-th rising edge.
  - A tick with tvalid = 1 & tready = 0 is dropped and sets overrun; overrun clears only on reset.
  - tvalid = 1 & tready = 0: tdata, tlast and tvalid are held stable (AXIS rule).
  - Handshake without a simultaneous tick: tvalid drops to 0 next cycle.
  - With DIVIDER = 1 and tready held high, one beat is transferred every cycle.
- Mode sampling: mode is sampled into active_mode only when a beat is loaded with beat_cnt = 0. A change of active_mode resets value = COUNTER_START, dir = up and lfsr = LFSR_SEED before generating that beat.
- Pattern advance: once per loaded beat, after the beat's data is captured. Arithmetic uses TDATA_WIDTH+1 bits to detect overflow.
  - Sawtooth: next = value + INCR; if next > END, next = START.
  - Triangle, dir up: next = value + INCR; if next > END, then next = value - INCR and dir = down.
  - Triangle, dir down: next = value - INCR; if next < START or it underflows, then next = value + INCR and dir = up.
  - Constant: value stays START.
  - PRBS: 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, shifts one step per beat.
- Channel data, truncated to TDATA_WIDTH:
  - Counter/constant modes: channel c = value + c*COUNTER_INCR (mod 2^TDATA_WIDTH); in constant mode every channel = START.
  - PRBS: channel c = low TDATA_WIDTH bits of (lfsr XOR c*32'h9E37_79B9).
- Framing:
  - beat_cnt increments on each handshake and wraps at PACKET_LEN-1.
  - tlast = 1 on the beat loaded while beat_cnt = PACKET_LEN-1.
  - PACKET_LEN = 1 gives tlast on every beat.
- Reset mid-packet or while a beat is pending: the beat is discarded and the next packet starts fresh.

Test Plan:
- Defaults, tready = 1, mode = 0 → ch0 = 1,2,…,10,1,2…; ch1 = ch0+1; beats every 5 cycles; first tvalid on the 5th edge after reset; tlast on beats 8, 16…
- mode = 1, START = 1, END = 10, INCR = 3 → ch0 = 1,4,7,10,7,4,1,4…; no value outside 1..10.
- tready = 0 for 300 ns (15 cycles, 3 ticks) mid-stream → tdata/tlast frozen, overrun = 1 and stays 1; after tready = 1 the frozen beat transfers and the next value follows it, with no skipped pattern step.
- enable = 0 for 500 ns then 1 → no new tvalid while low; pending beat still completes; first beat after re-enable appears DIVIDER cycles after enable rises and continues the sequence.
- mode switched 0→3 at beat 3 of a packet → beats 4..8 remain sawtooth; beat 9 is PRBS from LFSR_SEED (ch0 = 0x000001 with 24-bit channels); bench LFSR model matches every subsequent beat.
- Async reset asserted mid-packet with tvalid = 1 → tvalid, tlast, overrun = 0 immediately without a clock edge; after release, sequence restarts at START with beat_cnt = 0.

Source files
------------

// File: rtl/axis_testpattern_generator_mc.sv
// Multi-channel AXI-Stream test-pattern source: sawtooth, triangle, constant and PRBS
// samples, NUM_CHANNELS per beat, one beat per divider tick, framed with TLAST.
module axis_testpattern_generator_mc #(
    parameter int unsigned TDATA_WIDTH   = 24,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned COUNTER_START = 1,
    parameter int unsigned COUNTER_END   = 10,
    parameter int unsigned COUNTER_INCR  = 1,
    parameter int unsigned DIVIDER       = 5,
    parameter int unsigned PACKET_LEN    = 8,
    parameter logic [31:0] LFSR_SEED     = 32'h0000_0001
) (
    input  logic                                  m_axis_aclk,
    input  logic                                  m_axis_areset,
    input  logic                                  enable,
    input  logic [1:0]                            mode,
    output logic [NUM_CHANNELS*TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic                                  overrun
);

    typedef enum logic [1:0] {ModeSaw, ModeTri, ModeConst, ModePrbs} mode_e;

    localparam int unsigned Dw    = TDATA_WIDTH + 1;
    localparam int unsigned DivW  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int unsigned BeatW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

    localparam logic [DivW-1:0]        DivLast  = DivW'(DIVIDER - 1);
    localparam logic [BeatW-1:0]       BeatLast = BeatW'(PACKET_LEN - 1);
    localparam logic [TDATA_WIDTH-1:0] StartW   = TDATA_WIDTH'(COUNTER_START);
    localparam logic [Dw-1:0]          StartX   = Dw'(COUNTER_START);
    localparam logic [Dw-1:0]          EndX     = Dw'(COUNTER_END);
    localparam logic [Dw-1:0]          IncrX    = Dw'(COUNTER_INCR);
    localparam logic [31:0]            Golden   = 32'h9E37_79B9;

    logic [DivW-1:0]                        div_q;
    logic [BeatW-1:0]                       beat_q;
    logic [TDATA_WIDTH-1:0]                 value_q, value_d;
    logic                                   dir_q, dir_d;       // 0 = up, 1 = down
    logic [31:0]                            lfsr_q, lfsr_d;
    mode_e                                  mode_q;
    logic [NUM_CHANNELS*TDATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic                                   tvalid_q, tlast_q, overrun_q;

    logic                   tick, handshake, load, restart;
    logic [BeatW-1:0]       beat_idx;
    mode_e                  gen_mode;
    logic [TDATA_WIDTH-1:0] cur_value;
    logic                   cur_dir;
    logic [31:0]            cur_lfsr;
    logic [Dw-1:0]          up_x, dn_x;

    // One channel's sample for the given pattern state
    function automatic logic [TDATA_WIDTH-1:0] chan_sample(input mode_e m,
                                                           input logic [TDATA_WIDTH-1:0] v,
                                                           input logic [31:0] l,
                                                           input int unsigned c);
        unique case (m)
            ModePrbs:  return TDATA_WIDTH'(l ^ (c * Golden));
            ModeConst: return StartW;
            default:   return TDATA_WIDTH'(32'(v) + c * COUNTER_INCR);
        endcase
    endfunction

    // Tick, handshake and beat-index decode; beat_idx is the index of a beat loaded now
    always_comb begin
        tick      = enable && (div_q == DivLast);
        handshake = tvalid_q && m_axis_tready;
        load      = tick && (!tvalid_q || m_axis_tready);
        beat_idx  = beat_q;
        if (handshake) begin
            beat_idx = (beat_q == BeatLast) ? '0 : beat_q + 1'b1;
        end
        // Mode is only sampled at packet starts; a change restarts the pattern
        gen_mode  = (beat_idx == '0) ? mode_e'(mode) : mode_q;
        restart   = (beat_idx == '0) && (mode_e'(mode) != mode_q);
        cur_value = restart ? StartW : value_q;
        cur_dir   = restart ? 1'b0 : dir_q;
        cur_lfsr  = restart ? LFSR_SEED : lfsr_q;
    end

    // Beat data and next pattern state; one extra bit exposes overflow and underflow
    always_comb begin
        tdata_d = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            tdata_d[c*TDATA_WIDTH +: TDATA_WIDTH] = chan_sample(gen_mode, cur_value, cur_lfsr, c);
        end
        up_x    = {1'b0, cur_value} + IncrX;
        dn_x    = {1'b0, cur_value} - IncrX;
        value_d = cur_value;
        dir_d   = cur_dir;
        lfsr_d  = cur_lfsr;
        unique case (gen_mode)
            ModeSaw: begin
                value_d = (up_x > EndX) ? StartW : up_x[TDATA_WIDTH-1:0];
            end
            ModeTri: begin
                if (!cur_dir) begin
                    if (up_x > EndX) begin
                        value_d = dn_x[TDATA_WIDTH-1:0];
                        dir_d   = 1'b1;
                    end else begin
                        value_d = up_x[TDATA_WIDTH-1:0];
                    end
                end else if (dn_x[TDATA_WIDTH] || (dn_x < StartX)) begin
                    value_d = up_x[TDATA_WIDTH-1:0];
                    dir_d   = 1'b0;
                end else begin
                    value_d = dn_x[TDATA_WIDTH-1:0];
                end
            end
            ModeConst: begin
                value_d = StartW;
            end
            ModePrbs: begin
                // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1
                lfsr_d = {cur_lfsr[30:0],
                          cur_lfsr[31] ^ cur_lfsr[21] ^ cur_lfsr[1] ^ cur_lfsr[0]};
            end
            default: ;
        endcase
    end

    // Divider, framing, pattern state and registered AXIS outputs
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            div_q     <= '0;
            beat_q    <= '0;
            value_q   <= StartW;
            dir_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            mode_q    <= ModeSaw;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (!enable || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            beat_q <= beat_idx;
            if (tick && tvalid_q && !m_axis_tready) begin
                overrun_q <= 1'b1;
            end
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= tdata_d;
                tlast_q  <= (beat_idx == BeatLast);
                mode_q   <= gen_mode;
                value_q  <= value_d;
                dir_q    <= dir_d;
                lfsr_q   <= lfsr_d;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign overrun       = overrun_q;

endmodule
